// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and default timing.
// Used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam int OVERSAMPLE_DEFAULT = 16;

  // Mode 3 is reserved and behaves as no parity.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts oversampling ticks within one bit period and flags the last tick.
// i_clear holds the counter at zero (used while the line is idle).
module uart_bit_timer #(
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE_DEFAULT
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_bit_end
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] tick_cnt;

  assign o_bit_end = i_tick && !i_clear && (tick_cnt == LAST);

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      tick_cnt <= '0;
    end else if (i_tick) begin
      tick_cnt <= o_bit_end ? '0 : tick_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Runtime-configurable UART transmitter: one-entry holding register feeding an
// LSB-first serialiser with start, 5..NB_DATA data, optional parity and 1-2 stop bits.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int NB_DATA    = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int NB_LEN     = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_LEN-1:0]  i_cfg_data_len,
  input  logic [1:0]         i_cfg_parity,
  input  logic               i_cfg_two_stop,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_tx_done,
  output uart_state_t        o_state
);

  // Handshake: a byte transfers on any edge where i_valid && o_ready; o_ready is
  // simply "holding register empty" and never depends on i_valid.

  uart_state_t        state, state_next;
  logic               hold_full;
  logic [NB_DATA-1:0] hold_data;
  logic [NB_DATA-1:0] shifter;
  logic [NB_LEN-1:0]  bit_cnt;
  logic               stop_cnt;
  logic [NB_LEN-1:0]  cfg_len;
  logic               cfg_par_en;
  logic               cfg_par_bit;
  logic               cfg_two_stop;

  logic               bit_end;
  logic               write;
  logic               load;
  logic               shift;
  logic               bit_inc;
  logic               stop_inc;
  logic               tx_next;
  logic               done_next;
  logic               data_last;
  logic               stop_last;
  logic [NB_LEN-1:0]  len_eff;
  logic [NB_DATA-1:0] len_mask;
  logic               par_calc;

  assign o_ready   = !hold_full;
  assign write     = i_valid && o_ready;
  assign o_state   = state;
  assign data_last = (bit_cnt == cfg_len - NB_LEN'(1));
  assign stop_last = (stop_cnt == cfg_two_stop);

  uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_bit_timer (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (state == ST_IDLE),
    .i_tick   (i_tick),
    .o_bit_end(bit_end)
  );

  // Frame configuration derived from the live inputs; only captured on load.
  always_comb begin
    len_eff = i_cfg_data_len;
    if (int'(i_cfg_data_len) < 5 || int'(i_cfg_data_len) > NB_DATA) begin
      len_eff = NB_LEN'(NB_DATA);
    end
    for (int i = 0; i < NB_DATA; i++) begin
      len_mask[i] = (i < int'(len_eff));
    end
    par_calc = ^(hold_data & len_mask);
    if (i_cfg_parity == PAR_ODD) begin
      par_calc = ~par_calc;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (hold_full) state_next = ST_START;
      ST_START:  if (bit_end) state_next = ST_DATA;
      ST_DATA:   if (bit_end && data_last) state_next = cfg_par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_next = ST_STOP;
      ST_STOP:   if (bit_end && stop_last) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy    = (state != ST_IDLE);
    load      = 1'b0;
    shift     = 1'b0;
    bit_inc   = 1'b0;
    stop_inc  = 1'b0;
    done_next = 1'b0;
    tx_next   = o_tx;
    case (state)
      ST_IDLE: begin
        if (hold_full) begin
          load    = 1'b1;
          tx_next = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          tx_next = shifter[0];
          shift   = 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (data_last) begin
            tx_next = cfg_par_en ? cfg_par_bit : 1'b1;
          end else begin
            tx_next = shifter[0];
            shift   = 1'b1;
            bit_inc = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) tx_next = 1'b1;
      end
      ST_STOP: begin
        tx_next = 1'b1;
        if (bit_end) begin
          if (stop_last) done_next = 1'b1;
          else           stop_inc  = 1'b1;
        end
      end
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      hold_full <= 1'b0;
      o_tx      <= 1'b1;
      o_tx_done <= 1'b0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
    end else begin
      o_tx      <= tx_next;
      o_tx_done <= done_next;
      if (load) begin
        hold_full <= 1'b0;
      end else if (write) begin
        hold_full <= 1'b1;
      end
      if (load) begin
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
      end else begin
        if (bit_inc)  bit_cnt  <= bit_cnt + NB_LEN'(1);
        if (stop_inc) stop_cnt <= 1'b1;
      end
    end
  end

  // Payload and latched configuration need no reset: they are only read after a load.
  always_ff @(posedge i_clock) begin
    if (write) begin
      hold_data <= i_data;
    end
    if (load) begin
      shifter      <= hold_data;
      cfg_len      <= len_eff;
      cfg_par_en   <= parity_enabled(i_cfg_parity);
      cfg_par_bit  <= par_calc;
      cfg_two_stop <= i_cfg_two_stop;
    end else if (shift) begin
      shifter <= shifter >> 1;
    end
  end

endmodule
